// File: rtl/conv_stream_layer.sv
// Streaming KxK convolution over a raster pixel stream: line buffers build the
// window, a two-stage MAC/activation pipeline produces one feature per stride step.
module conv_stream_layer #(
    parameter int KERNEL_SIZE = 3,
    parameter int IMGCOL      = 32,
    parameter int IMGROW      = 32,
    parameter int IN_CH       = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int KDATA_WIDTH = 8,
    parameter int STRIDE      = 1,
    parameter     ACTIVATION  = "RELU"
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic                                                 kernel_load,
    input  logic [IN_CH*KERNEL_SIZE*KERNEL_SIZE*KDATA_WIDTH-1:0] kernel_in,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [IN_CH*DATA_WIDTH-1:0]                          in_data,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [DATA_WIDTH-1:0]                                out_data,
    output logic                                                 frame_done
);

    localparam int K       = KERNEL_SIZE;
    localparam int TAPS    = IN_CH * K * K;
    localparam int KER_W   = TAPS * KDATA_WIDTH;
    localparam int LB_ROWS = (K > 1) ? K - 1 : 1;
    localparam int COL_W   = (IMGCOL > 1) ? $clog2(IMGCOL) : 1;
    localparam int ROW_W   = (IMGROW > 1) ? $clog2(IMGROW) : 1;
    localparam int PROD_W  = DATA_WIDTH + KDATA_WIDTH + 1;
    localparam int ACC_W   = PROD_W + $clog2(TAPS + 1);
    localparam int FRAC    = KDATA_WIDTH - 2;
    localparam bit IS_RELU = (ACTIVATION == "RELU");

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMGCOL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMGROW - 1);
    localparam logic [31:0]      KM1      = 32'(K - 1);
    localparam logic [31:0]      STRIDE_U = 32'(STRIDE);

    localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((1 << DATA_WIDTH) - 1);
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(1 << (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [KER_W-1:0]        kernel_q, kernel_d;
    logic [DATA_WIDTH-1:0]   win_q [IN_CH][K][K];
    logic [DATA_WIDTH-1:0]   win_d [IN_CH][K][K];
    logic [DATA_WIDTH-1:0]   lb_q  [IN_CH][LB_ROWS][IMGCOL];
    logic [DATA_WIDTH-1:0]   lb_d  [IN_CH][LB_ROWS][IMGCOL];
    logic                    win_valid_q, win_valid_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic                    sum_valid_q, sum_valid_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

    logic                    stall, accept, last_pix, row_ok, col_ok;
    logic signed [ACC_W-1:0] acc;
    logic signed [PROD_W-1:0] pix_ext, ker_ext;
    logic [DATA_WIDTH-1:0]   act_data;

    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = (state_q == RUN) && !stall;
    assign accept     = in_valid && in_ready;
    assign last_pix   = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = (state_q == DONE);

    // A window is emitted when the accepted pixel is the bottom-right of a stride-aligned KxK block.
    assign row_ok = (32'(row_q) >= KM1) && (((32'(row_q) - KM1) % STRIDE_U) == 32'd0);
    assign col_ok = (32'(col_q) >= KM1) && (((32'(col_q) - KM1) % STRIDE_U) == 32'd0);

    always_comb begin
        state_d  = state_q;
        kernel_d = kernel_q;
        row_d    = row_q;
        col_d    = col_q;
        unique case (state_q)
            IDLE: begin
                if (kernel_load) kernel_d = kernel_in;
                if (start)       state_d  = RUN;
            end
            RUN:     if (last_pix) state_d = DRAIN;
            DRAIN:   if (!win_valid_q && !sum_valid_q && !out_valid_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (last_pix) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == COL_LAST) begin
                row_d = row_q + 1'b1;
                col_d = '0;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window shifts left one column per accepted pixel; the new column comes from the line buffers.
    always_comb begin
        win_d       = win_q;
        lb_d        = lb_q;
        win_valid_d = win_valid_q;
        if (!stall) win_valid_d = accept && row_ok && col_ok;
        if (accept) begin
            for (int ch = 0; ch < IN_CH; ch++) begin
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K - 1; j++)
                        win_d[ch][i][j] = win_q[ch][i][j+1];
                for (int i = 0; i < K - 1; i++)
                    win_d[ch][i][K-1] = lb_q[ch][K-2-i][col_q];
                win_d[ch][K-1][K-1] = in_data[ch*DATA_WIDTH +: DATA_WIDTH];
                for (int m = K - 2; m > 0; m--)
                    lb_d[ch][m][col_q] = lb_q[ch][m-1][col_q];
                if (K > 1) lb_d[ch][0][col_q] = in_data[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        acc     = '0;
        pix_ext = '0;
        ker_ext = '0;
        for (int ch = 0; ch < IN_CH; ch++) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    pix_ext = PROD_W'($signed({1'b0, win_q[ch][i][j]}));
                    ker_ext = PROD_W'($signed(kernel_q[((ch*K + i)*K + j)*KDATA_WIDTH +: KDATA_WIDTH]));
                    acc     = acc + ACC_W'(pix_ext * ker_ext);
                end
            end
        end
    end

    always_comb begin
        act_data = '0;
        if (IS_RELU) begin
            if (sum_q[ACC_W-1])     act_data = '0;
            else if (sum_q > U_MAX) act_data = '1;
            else                    act_data = sum_q[DATA_WIDTH-1:0];
        end else begin
            if (sum_q > S_MAX)      act_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            else if (sum_q < S_MIN) act_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else                    act_data = sum_q[DATA_WIDTH-1:0];
        end
    end

    // NOTE: every pipeline stage advances only when not stalled, so a held output freezes the whole datapath.
    always_comb begin
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            sum_d       = acc >>> FRAC;
            sum_valid_d = win_valid_q;
            out_valid_d = sum_valid_q;
            if (sum_valid_q) out_data_d = act_data;
        end
    end

    // NOTE: line buffers and window are cleared on reset so no pixel of an aborted frame survives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            kernel_q    <= '0;
            win_q       <= '{default: '0};
            lb_q        <= '{default: '0};
            win_valid_q <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            kernel_q    <= kernel_d;
            win_q       <= win_d;
            lb_q        <= lb_d;
            win_valid_q <= win_valid_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_conv_stream_layer.sv
// Directed bench: a 4x4 stride-1 RELU instance and a 5x5 stride-2 NONE instance,
// both two-channel, sharing stimulus and checked against hand-computed features.
module tb_conv_stream_layer;

    localparam int K     = 3;
    localparam int CH    = 2;
    localparam int KER_W = CH * K * K * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start_a, start_b, kernel_load, in_valid, out_ready;
    logic [KER_W-1:0] kernel_in;
    logic [CH*8-1:0]  in_data;
    logic             rdy_a, ov_a, fd_a, rdy_b, ov_b, fd_b;
    logic [7:0]       od_a, od_b;

    conv_stream_layer #(.KERNEL_SIZE(3), .IMGCOL(4), .IMGROW(4), .IN_CH(2), .DATA_WIDTH(8),
                        .KDATA_WIDTH(8), .STRIDE(1), .ACTIVATION("RELU")) u_a (
        .clk(clk), .rst(rst), .start(start_a), .kernel_load(kernel_load), .kernel_in(kernel_in),
        .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .frame_done(fd_a));

    conv_stream_layer #(.KERNEL_SIZE(3), .IMGCOL(5), .IMGROW(5), .IN_CH(2), .DATA_WIDTH(8),
                        .KDATA_WIDTH(8), .STRIDE(2), .ACTIVATION("NONE")) u_b (
        .clk(clk), .rst(rst), .start(start_b), .kernel_load(kernel_load), .kernel_in(kernel_in),
        .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .frame_done(fd_b));

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_v [4];
    bit         pix_ramp;
    logic [7:0] pix0, pix1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [KER_W-1:0] uni_kernel(input logic [7:0] k0, input logic [7:0] k1);
        logic [KER_W-1:0] r;
        r = '0;
        for (int t = 0; t < K*K; t++) begin
            r[t*8 +: 8]       = k0;
            r[(K*K+t)*8 +: 8] = k1;
        end
        return r;
    endfunction

    function automatic logic [KER_W-1:0] tap(input int ch, input int i, input int j, input logic [7:0] v);
        logic [KER_W-1:0] r;
        r = '0;
        r[((ch*K + i)*K + j)*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [CH*8-1:0] pixel(input int idx);
        return pix_ramp ? {pix1, 8'(idx)} : {pix1, pix0};
    endfunction

    task automatic load_kernel(input logic [KER_W-1:0] k);
        kernel_in   = k;
        kernel_load = 1'b1;
        @(posedge clk); #1;
        kernel_load = 1'b0;
    endtask

    task automatic start_frame(input bit sel, input bit with_load, input logic [KER_W-1:0] k);
        if (with_load) begin
            kernel_in   = k;
            kernel_load = 1'b1;
        end
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a     = 1'b0;
        start_b     = 1'b0;
        kernel_load = 1'b0;
    endtask

    // Streams npix pixels, collects outputs, optionally stalls 5 cycles on the first
    // output or tries a kernel_load mid-run, then checks values, count, latency, frame_done.
    task automatic run_frame(input bit sel, input int npix, input int br_idx,
                             input bit stall_mode, input bit klate, input string tag);
        int         idx, nout, first_cyc, acc_cyc, hold, done_cnt;
        bit         stalled, seen, rdy, ov, fd, acc;
        logic [7:0] od, held;
        logic [7:0] got [4];
        idx = 0; nout = 0; first_cyc = -1; acc_cyc = -1; hold = 0; done_cnt = 0;
        stalled = 0; seen = 0; held = '0;
        got = '{default: '0};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            in_valid = (idx < npix);
            in_data  = pixel(idx);
            if (klate && cyc == 2) begin
                kernel_in   = uni_kernel(8'h40, 8'h40);
                kernel_load = 1'b1;
            end
            @(negedge clk);
            if (!out_ready && hold == 0) out_ready = 1'b1;
            ov = sel ? ov_b : ov_a;
            if (stall_mode && !stalled && ov) begin
                out_ready = 1'b0;
                stalled   = 1;
                hold      = 5;
                held      = sel ? od_b : od_a;
            end
            #1;
            rdy = sel ? rdy_b : rdy_a;
            ov  = sel ? ov_b  : ov_a;
            od  = sel ? od_b  : od_a;
            fd  = sel ? fd_b  : fd_a;
            if (hold > 0) begin
                check({tag, "_stall_valid"}, 32'(ov), 32'd1);
                check({tag, "_stall_data"}, 32'(od), 32'(held));
                check({tag, "_stall_ready"}, 32'(rdy), 32'd0);
                hold--;
            end
            acc = in_valid && rdy;
            if (acc && idx == br_idx) acc_cyc = cyc;
            if (ov && first_cyc < 0) first_cyc = cyc;
            if (ov && out_ready) begin
                if (nout < 4) got[nout] = od;
                nout++;
            end
            if (fd) begin
                seen = 1;
                done_cnt++;
            end
            @(posedge clk); #1;
            kernel_load = 1'b0;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (sel ? fd_b : fd_a) done_cnt++;
            if (sel ? ov_b : ov_a) nout++;
        end
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_out_count"}, 32'(nout), 32'd4);
        check({tag, "_latency"}, 32'(first_cyc - acc_cyc), 32'd3);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_out%0d", tag, i), 32'(got[i]), 32'(exp_v[i]));
    endtask

    initial begin
        bit bad_ov, bad_fd;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; kernel_load = 1'b0;
        kernel_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        pix_ramp = 0; pix0 = '0; pix1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", 32'(rdy_a), 32'd0);
        check("rst_a_valid", 32'(ov_a), 32'd0);
        check("rst_a_data", 32'(od_a), 32'd0);
        check("rst_a_done", 32'(fd_a), 32'd0);
        check("rst_b_ready", 32'(rdy_b), 32'd0);
        check("rst_b_valid", 32'(ov_b), 32'd0);
        check("rst_b_data", 32'(od_b), 32'd0);
        check("rst_b_done", 32'(fd_b), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // all-ones image, unit kernel: 9 taps of 1.0 -> 9
        pix0 = 8'd1; pix1 = 8'd0;
        load_kernel(uni_kernel(8'h40, 8'h00));
        start_frame(0, 0, '0);
        exp_v = '{8'd9, 8'd9, 8'd9, 8'd9};
        run_frame(0, 16, 10, 0, 0, "ones");

        // ramp image, single tap at [1][2] on ch0 plus ch1 tap [0][0] on constant 3
        pix_ramp = 1; pix1 = 8'd3;
        start_frame(0, 1, tap(0, 1, 2, 8'h40) | tap(1, 0, 0, 8'h40));
        exp_v = '{8'd9, 8'd10, 8'd13, 8'd14};
        run_frame(0, 16, 10, 0, 0, "ramp");

        // negative kernel under RELU clamps to 0; a kernel_load during RUN is ignored
        pix_ramp = 0; pix0 = 8'd10; pix1 = 8'd0;
        load_kernel(uni_kernel(8'hC0, 8'h00));
        start_frame(0, 0, '0);
        exp_v = '{8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(0, 16, 10, 0, 1, "neg_relu");

        // saturation to 255 with ch1 weights zero, plus 5-cycle output stall
        pix0 = 8'd255; pix1 = 8'd255;
        load_kernel(uni_kernel(8'h40, 8'h00));
        start_frame(0, 0, '0);
        exp_v = '{8'd255, 8'd255, 8'd255, 8'd255};
        run_frame(0, 16, 10, 1, 0, "sat_relu");

        // stride 2 on 5x5: windows (0,0),(0,2),(2,0),(2,2)
        pix0 = 8'd2; pix1 = 8'd255;
        load_kernel(uni_kernel(8'h40, 8'h00));
        start_frame(1, 0, '0);
        exp_v = '{8'd18, 8'd18, 8'd18, 8'd18};
        run_frame(1, 25, 12, 0, 0, "stride2");

        // NONE activation: -90 as two's complement
        pix0 = 8'd10; pix1 = 8'd0;
        load_kernel(uni_kernel(8'hC0, 8'h00));
        start_frame(1, 0, '0);
        exp_v = '{8'hA6, 8'hA6, 8'hA6, 8'hA6};
        run_frame(1, 25, 12, 0, 0, "neg_none");

        // NONE activation saturates 2295 to +127
        pix0 = 8'd255; pix1 = 8'd255;
        load_kernel(uni_kernel(8'h40, 8'h00));
        start_frame(1, 0, '0);
        exp_v = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        run_frame(1, 25, 12, 0, 0, "sat_none");

        // reset mid-frame with a window in flight
        pix0 = 8'd1; pix1 = 8'd0;
        load_kernel(uni_kernel(8'h40, 8'h00));
        start_frame(0, 0, '0);
        in_valid = 1'b1;
        in_data  = pixel(0);
        repeat (12) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", 32'(rdy_a), 32'd0);
        check("midrst_valid", 32'(ov_a), 32'd0);
        check("midrst_data", 32'(od_a), 32'd0);
        check("midrst_done", 32'(fd_a), 32'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        bad_ov = 0; bad_fd = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (ov_a) bad_ov = 1;
            if (fd_a) bad_fd = 1;
        end
        check("midrst_no_stale_out", 32'(bad_ov), 32'd0);
        check("midrst_no_stale_done", 32'(bad_fd), 32'd0);

        // reset cleared the kernel: a frame without reload yields zeros
        start_frame(0, 0, '0);
        exp_v = '{8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(0, 16, 10, 0, 0, "cleared_kernel");

        load_kernel(uni_kernel(8'h40, 8'h00));
        start_frame(0, 0, '0);
        exp_v = '{8'd9, 8'd9, 8'd9, 8'd9};
        run_frame(0, 16, 10, 0, 0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
